// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one iterative divide core among NUM_REQ requesters.
// Zero divisors are answered locally; a watchdog bounds the wait for the core.
module div_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 40,
   localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
   output logic                     div_start,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic                     div_done,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_remainder,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [WIDTH-1:0]         rsp_quotient,
   output logic [WIDTH-1:0]         rsp_remainder,
   output logic                     rsp_dbz,
   output logic                     rsp_err,
   output logic                     busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q,  state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] opa_q,    opa_d;
   logic [WIDTH-1:0] opb_q,    opb_d;
   logic [IDW-1:0]   id_q,     id_d;
   logic [WIDTH-1:0] quot_q,   quot_d;
   logic [WIDTH-1:0] rem_q,    rem_d;
   logic             dbz_q,    dbz_d;
   logic             err_q,    err_d;

   logic             grant_vld;
   logic [IDW-1:0]   grant_idx;
   logic [WIDTH-1:0] grant_a;
   logic [WIDTH-1:0] grant_b;
   logic [IDW-1:0]   grant_next;

   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDW'(sum);
   endfunction

   // Walk candidates from farthest to nearest so the nearest valid one wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[rr_index(rr_ptr_q, k)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_index(rr_ptr_q, k);
         end
      end
   end

   assign grant_a    = req_dividend[grant_idx*WIDTH +: WIDTH];
   assign grant_b    = req_divisor[grant_idx*WIDTH +: WIDTH];
   assign grant_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      id_d      = id_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      err_d     = err_q;
      req_ready = '0;
      div_start = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               req_ready[grant_idx] = 1'b1;
               rr_ptr_d = grant_next;
               id_d     = grant_idx;
               opa_d    = grant_a;
               opb_d    = grant_b;
               err_d    = 1'b0;
               if (grant_b == '0) begin
                  quot_d  = '1;
                  rem_d   = grant_a;
                  dbz_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  dbz_d   = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            div_start = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A completion in the last watchdog cycle still counts as success.
            if (div_done) begin
               quot_d  = div_quotient;
               rem_d   = div_remainder;
               state_d = S_RESP;
            end else if (cnt_q == TO_LAST) begin
               quot_d  = '0;
               rem_d   = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         id_q     <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         dbz_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         id_q     <= id_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         dbz_q    <= dbz_d;
         err_q    <= err_d;
      end
   end

   assign div_dividend  = opa_q;
   assign div_divisor   = opb_q;
   assign rsp_valid     = (state_q == S_RESP);
   assign rsp_id        = id_q;
   assign rsp_quotient  = quot_q;
   assign rsp_remainder = rem_q;
   assign rsp_dbz       = dbz_q;
   assign rsp_err       = err_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: the bench plays requesters and divide core, and keeps
// a transaction-level scoreboard of expected grants, results and response latencies.
module tb_div_share_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TO = 40;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_dividend;
   logic [N*W-1:0] req_divisor;
   logic           div_start;
   logic [W-1:0]   div_dividend;
   logic [W-1:0]   div_divisor;
   logic           div_done;
   logic [W-1:0]   div_quotient;
   logic [W-1:0]   div_remainder;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_quotient;
   logic [W-1:0]   rsp_remainder;
   logic           rsp_dbz;
   logic           rsp_err;
   logic           busy;

   always #5 clk = ~clk;

   div_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_dbz(rsp_dbz), .rsp_err(rsp_err), .busy(busy)
   );

   typedef struct {
      int          id;
      logic [15:0] a, b, q, r;
      bit          dbz, err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   int          n_checks = 0, n_errors = 0;
   int          cyc = 0, m_ptr = 0;
   int          cur_lat = 5, next_lat = 5, cur_starts = 0;
   int          viol = 0, stab_viol = 0, rand_acc = 0;
   bit          lat_rand = 0, rand_gen = 0, rand_rdy = 0;
   bit          in_resp = 0, prev_hs = 0, force_done = 0;
   logic [1:0]  s_id;
   logic [15:0] s_q, s_r;
   logic        s_dbz, s_err;
   bit          pend[N];
   bit          acc_flag[N];
   logic [15:0] pa[N], pb[N];
   int          core_cnt = 0;
   logic [15:0] core_q, core_r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pick_lat();
      int r;
      if (!lat_rand) return next_lat;
      r = $urandom_range(0, 15);
      if (r == 0) return -1;
      if (r == 1) return TO;
      if (r == 2) return 1;
      return $urandom_range(1, 20);
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = pend[i];
         req_dividend[i*W +: W] = pa[i];
         req_divisor[i*W +: W]  = pb[i];
      end
   endtask

   task automatic post(input int i, input logic [15:0] a, input logic [15:0] b);
      pend[i] = 1'b1;
      pa[i]   = a;
      pb[i]   = b;
      drive();
   endtask

   task automatic monitor();
      exp_t e;
      int   expg;
      bit   found;
      if (rst) begin
         sb.delete();
         m_ptr    = 0;
         in_resp  = 0;
         prev_hs  = 0;
         core_cnt = 0;
         return;
      end
      if (prev_hs) chk("idle_after_rsp", busy, 0);
      prev_hs = 0;
      if (req_ready != '0 && busy) viol++;
      if ($countones(req_ready) > 1) viol++;
      if ((req_ready & ~req_valid) != '0) viol++;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            found = 0;
            expg  = -1;
            for (int k = 0; k < N; k++) begin
               if (!found && req_valid[(m_ptr + k) % N]) begin
                  found = 1;
                  expg  = (m_ptr + k) % N;
               end
            end
            chk("grant", i, expg);
            m_ptr = (i + 1) % N;
            grant_log.push_back(i);
            acc_flag[i] = 1;
            e.id  = i;
            e.a   = pa[i];
            e.b   = pb[i];
            e.acc = cyc;
            e.dbz = 0;
            e.err = 0;
            if (pb[i] == 16'd0) begin
               e.q   = 16'hFFFF;
               e.r   = pa[i];
               e.dbz = 1;
               e.lat = 1;
            end else begin
               cur_lat = pick_lat();
               if (cur_lat < 0) begin
                  e.q   = 16'd0;
                  e.r   = 16'd0;
                  e.err = 1;
                  e.lat = 2 + TO;
               end else begin
                  e.q   = pa[i] / pb[i];
                  e.r   = pa[i] % pb[i];
                  e.lat = 2 + cur_lat;
               end
            end
            sb.push_back(e);
            cur_starts = 0;
            if (rand_gen) rand_acc++;
         end
      end
      if (div_start) begin
         cur_starts++;
         if (sb.size() > 0) begin
            chk("core_dividend", div_dividend, sb[0].a);
            chk("core_divisor", div_divisor, sb[0].b);
         end
         if (cur_lat >= 0) core_cnt = cur_lat;
         core_q = (div_divisor != 0) ? div_dividend / div_divisor : 16'd0;
         core_r = (div_divisor != 0) ? div_dividend % div_divisor : 16'd0;
      end
      if (rsp_valid) begin
         if (!in_resp) begin
            in_resp = 1;
            s_id = rsp_id; s_q = rsp_quotient; s_r = rsp_remainder;
            s_dbz = rsp_dbz; s_err = rsp_err;
            if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
         end else if (s_id !== rsp_id || s_q !== rsp_quotient || s_r !== rsp_remainder ||
                      s_dbz !== rsp_dbz || s_err !== rsp_err) begin
            stab_viol++;
         end
         if (rsp_ready) begin
            in_resp = 0;
            prev_hs = 1;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_quotient", rsp_quotient, e.q);
               chk("rsp_remainder", rsp_remainder, e.r);
               chk("rsp_dbz", rsp_dbz, e.dbz);
               chk("rsp_err", rsp_err, e.err);
               chk("core_starts", cur_starts, e.dbz ? 0 : 1);
            end
         end
      end
   endtask

   task automatic core_update();
      div_done      = 1'b0;
      div_quotient  = 16'($urandom);
      div_remainder = 16'($urandom);
      if (force_done) begin
         div_done   = 1'b1;
         force_done = 0;
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            div_done      = 1'b1;
            div_quotient  = core_q;
            div_remainder = core_r;
         end
      end
   endtask

   task automatic driver_update();
      logic [15:0] a, b;
      for (int i = 0; i < N; i++) begin
         if (acc_flag[i]) begin
            pend[i]     = 0;
            acc_flag[i] = 0;
         end
      end
      if (rand_gen) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               a = 16'($urandom);
               if ($urandom_range(0, 7) == 0) b = 16'd0;
               else if ($urandom_range(0, 1) == 0) b = 16'($urandom_range(1, 15));
               else b = 16'($urandom);
               post(i, a, b);
            end
         end
      end
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      drive();
   endtask

   task automatic cycle();
      #1;
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      core_update();
      driver_update();
   endtask

   task automatic wait_drain(input int max);
      int  n = 0;
      bit  anyp;
      anyp = 1;
      while (anyp && n < max) begin
         anyp = (sb.size() != 0) || busy || in_resp;
         for (int i = 0; i < N; i++) if (pend[i]) anyp = 1;
         if (anyp) begin
            cycle();
            n++;
         end
      end
      chk("drain_queue", sb.size(), 0);
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_dbz", rsp_dbz, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_quotient", rsp_quotient, 0);
      chk("rst_rsp_remainder", rsp_remainder, 0);
      rst = 1'b0;
      grant_log.delete();
   endtask

   initial begin
      int n;
      rst = 1'b1; rsp_ready = 1'b0; div_done = 1'b0;
      div_quotient = '0; div_remainder = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; acc_flag[i] = 0; pa[i] = '0; pb[i] = '0;
      end
      drive();

      // Single request, 17-cycle core
      do_reset();
      rsp_ready = 1'b1;
      next_lat  = 17;
      post(2, 16'd100, 16'd7);
      wait_drain(200);

      // Two full rounds with all requesters valid
      do_reset();
      rsp_ready = 1'b1;
      next_lat  = 3;
      for (int r = 0; r < 2; r++) begin
         post(0, 16'd1000, 16'd9);
         post(1, 16'd2001, 16'd10);
         post(2, 16'd65535, 16'd255);
         post(3, 16'd3, 16'd17);
         wait_drain(300);
      end
      chk("rr_count", grant_log.size(), 8);
      for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], k % 4);

      // Divide by zero
      post(1, 16'd1234, 16'd0);
      wait_drain(50);

      // Watchdog timeout
      next_lat = -1;
      post(3, 16'd999, 16'd5);
      wait_drain(300);

      // Response backpressure for 10 cycles
      rsp_ready = 1'b0;
      next_lat  = 4;
      post(0, 16'd5000, 16'd13);
      n = 0;
      while (!rsp_valid && n < 100) begin
         cycle();
         n++;
      end
      chk("bp_rsp_seen", rsp_valid, 1);
      post(1, 16'd77, 16'd7);
      post(2, 16'd88, 16'd8);
      repeat (10) cycle();
      chk("bp_still_valid", rsp_valid, 1);
      chk("bp_pending_held", {31'd0, pend[1] & pend[2]}, 1);
      chk("bp_stable", stab_viol, 0);
      rsp_ready = 1'b1;
      wait_drain(200);

      // Reset during WAIT, late done in IDLE
      grant_log.delete();
      next_lat = -1;
      post(2, 16'd500, 16'd3);
      repeat (8) cycle();
      chk("abort_busy_wait", busy, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("abort_idle", busy, 0);
      force_done = 1;
      cycle();
      repeat (3) cycle();
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_still_idle", busy, 0);
      grant_log.delete();
      next_lat = 6;
      post(0, 16'd4321, 16'd12);
      post(3, 16'd8, 16'd2);
      wait_drain(200);
      chk("abort_grants", grant_log.size(), 2);
      if (grant_log.size() > 0) chk("abort_first_grant", grant_log[0], 0);

      // Randomized traffic
      lat_rand = 1; rand_gen = 1; rand_rdy = 1;
      n = 0;
      while (rand_acc < 150 && n < 30000) begin
         cycle();
         n++;
      end
      rand_gen = 0; rand_rdy = 0; rsp_ready = 1'b1;
      wait_drain(1000);
      chk("rand_txns", (rand_acc >= 150) ? 1 : 0, 1);

      cycle();
      chk("ready_rules", viol, 0);
      chk("rsp_stable", stab_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Shares one iterative 16-bit restoring-divide core among `NUM_REQ` requesters. Each requester presents a dividend/divisor pair on a valid/ready channel. The block picks one requester by round-robin, sequences the core (start pulse, wait for done, watchdog), and returns quotient and remainder tagged with the requester id on a single valid/ready response channel. Divide-by-zero is resolved locally and never issued to the core.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 16: operand and result width.
- `TIMEOUT`, 40: maximum cycles spent in WAIT before the watchdog fires (must exceed the core latency).
- `IDW`, derived: `max(1, clog2(NUM_REQ))`.

- `clk`  in  1  sole clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_dividend`  in  NUM_REQ*WIDTH  flattened; requester i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- `req_divisor`  in  NUM_REQ*WIDTH  flattened, same packing as `req_dividend`.
- `div_start`  out  1  one-cycle start pulse to the core.
- `div_dividend`, `div_divisor`  out  WIDTH  registered operands to the core; held stable from start until the block leaves WAIT.
- `div_done`  in  1  core completion pulse.
- `div_quotient`, `div_remainder`  in  WIDTH  core results; valid only while `div_done` is high.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of the requester that was served.
- `rsp_quotient`, `rsp_remainder`  out  WIDTH  result.
- `rsp_dbz`  out  1  result is from a divide-by-zero.
- `rsp_err`  out  1  watchdog timeout; result fields are 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant `g` is the first `i` with `req_valid[i]` set, searching cyclically from `rr_ptr`.
  - `req_ready[g]` is asserted combinationally, and only in IDLE.
  - On acceptance, register the operands and `g`, then set `rr_ptr` to (g+1) mod NUM_REQ.
  - Divisor == 0: go to RESP with quotient = all-ones, remainder = dividend, `rsp_dbz` = 1.
  - Otherwise go to ISSUE.
- **ISSUE:** assert `div_start` for exactly one cycle, clear the watchdog counter, go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - If `div_done` is high, capture `div_quotient` and `div_remainder` and go to RESP.
  - Else, if counter == TIMEOUT-1, go to RESP with `rsp_err` = 1 and zero results.
  - If `div_done` and timeout coincide, `div_done` wins.
- **RESP:**
  - `rsp_valid` and all `rsp_*` fields are held stable until `rsp_valid && rsp_ready`, then return to IDLE.
  - No new request is accepted in the same cycle as that handshake.
- `div_done` outside WAIT is ignored.
- Results are passed through unmodified; the block performs no arithmetic except the zero-divisor check.
- Requesters that are not granted wait; `req_valid` must stay high and operands stable until `req_ready`.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` 0, counter 0.
  - `req_ready`, `div_start`, `rsp_valid`, `rsp_dbz`, `rsp_err`, `busy` all 0.
  - `div_dividend`, `div_divisor`, `rsp_id`, `rsp_quotient`, `rsp_remainder` all 0.
- Accept at cycle T → `div_start` at T+1 → core done at T+1+L → `rsp_valid` at T+2+L.
- Divide-by-zero: `rsp_valid` at T+1, and `div_start` is never pulsed.
- Minimum request-to-request spacing for non-zero divisors: L+3 cycles with `rsp_ready` held high.
- Reset mid-operation:
  - The block returns to IDLE the next cycle and any pending response is dropped.
  - A late `div_done` from the abandoned operation arrives in IDLE and is ignored.
  - Restarting the core is the core's own concern.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...

## Test plan
- Reset, then requester 2 sends 100/7, core returns after 17 cycles → `rsp_id`=2, quotient 14, remainder 2, `rsp_dbz`=0, `rsp_err`=0, `div_start` seen exactly once.
- All four requesters valid simultaneously with distinct operands → served in order 0,1,2,3. A second round also goes 0,1,2,3. No `req_ready` is asserted while `busy`.
- Requester 1 sends 1234/0 → `rsp_valid` one cycle after acceptance, quotient 0xFFFF, remainder 1234, `rsp_dbz`=1, `div_start` never asserted.
- Core never asserts `div_done` → `rsp_err`=1 exactly TIMEOUT cycles after the WAIT entry. Zero results. Block back in IDLE after `rsp_ready`.
- Hold `rsp_ready` low for 10 cycles after `rsp_valid` → response fields stable for all 10 cycles, no request accepted until the handshake.
- Assert `rst` during WAIT, then pulse `div_done` in IDLE → no `rsp_valid`, `rr_ptr` back to 0, next request from requester 0 served normally.
